// File: rtl/accum_job_sequencer.sv
// Accumulation-zone job sequencer: optional window clear, N accumulate passes, then an in-order drain.
// Optional perf counters are compiled in with `define ACCUM_SEQ_PERF_EN.
module accum_job_sequencer #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int ZONE_WIDTH = 2,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [ADDR_WIDTH-1:0]           job_base,
  input  logic [ADDR_WIDTH:0]             job_rows,
  input  logic [7:0]                      job_passes,
  input  logic [NUM_BANKS-1:0]            job_mask,
  input  logic [ZONE_WIDTH-1:0]           job_zone,
  input  logic                            job_clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  output logic                            wr_valid,
  output logic                            accum_en,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic [ZONE_WIDTH-1:0]           wr_zone_id,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_BANKS-1:0]            rd_mask,
  output logic [ZONE_WIDTH-1:0]           rd_zone_id,
  input  logic                            rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
  output logic                            busy,
  output logic                            done
`ifdef ACCUM_SEQ_PERF_EN
  ,
  output logic [31:0]                     perf_cycles,
  output logic [31:0]                     perf_stalls
`endif
);

  localparam int W  = NUM_BANKS * DATA_WIDTH;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_r, ptr;
  logic [ADDR_WIDTH:0]   rows_r, row_cnt, pop_cnt;
  logic [7:0]            passes_r, pass_cnt;
  logic [NUM_BANKS-1:0]  mask_r;
  logic [ZONE_WIDTH-1:0] zone_r;
  logic                  pend_a, pend_d;
  logic [CW-1:0]         outst, fcount;
  logic [PW-1:0]         wp, rp;
  logic [W-1:0]          mem [OUT_DEPTH];

  logic job_fire, pending, wr_complete, clear_issue, in_fire, rd_fire, pop, last_pop;

  assign job_fire    = job_valid && job_ready;
  assign pending     = pend_a || pend_d;
  // A row retires once both channels have handshaken, in whichever order they arrive.
  assign wr_complete = pending && (!pend_a || wr_ready) && (!pend_d || wready);
  assign clear_issue = (state == CLEAR) && (!pending || wr_complete) && (row_cnt != rows_r);
  assign in_fire     = in_valid && in_ready;
  assign rd_fire     = rd_valid && rd_ready;
  assign pop         = out_valid && out_ready;
  assign last_pop    = pop && (pop_cnt == rows_r - 1'b1);

  assign wr_valid   = pend_a;
  assign wvalid     = pend_d;
  assign wr_mask    = mask_r;
  assign wr_zone_id = zone_r;
  assign rd_addr    = ptr;
  assign rd_mask    = mask_r;
  assign rd_zone_id = zone_r;
  assign out_valid  = (fcount != '0);
  assign out_data   = mem[rp];
  assign out_last   = out_valid && (pop_cnt == rows_r - 1'b1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    job_ready = 1'b0;
    in_ready  = 1'b0;
    rd_valid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_fire)
          state_nxt = job_clear ? CLEAR : ((job_passes != 8'd0) ? ACCUM : DRAIN);
      end
      CLEAR: if (wr_complete && (row_cnt == rows_r))
        state_nxt = (passes_r != 8'd0) ? ACCUM : DRAIN;
      ACCUM: begin
        in_ready = !pending && (pass_cnt != passes_r);
        if (wr_complete && (pass_cnt == passes_r)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Read credits cover both in-flight reads and buffered rows, so the FIFO never overflows.
        rd_valid = (row_cnt != rows_r) &&
                   (({1'b0, outst} + {1'b0, fcount}) < (CW+1)'(OUT_DEPTH));
        if (last_pop) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_r <= '0; rows_r <= '0; passes_r <= '0; mask_r <= '0; zone_r <= '0;
      ptr <= '0; row_cnt <= '0; pass_cnt <= '0; pop_cnt <= '0;
      pend_a <= 1'b0; pend_d <= 1'b0; wr_addr <= '0; accum_en <= 1'b0;
      outst <= '0; fcount <= '0; wp <= '0; rp <= '0;
    end else begin
      if (job_fire) begin
        base_r   <= job_base;
        rows_r   <= (job_rows == '0) ? (ADDR_WIDTH+1)'(1) : job_rows;
        passes_r <= job_passes;
        mask_r   <= job_mask;
        zone_r   <= job_zone;
        ptr      <= job_base;
        row_cnt  <= '0;
        pass_cnt <= '0;
        pop_cnt  <= '0;
      end
      if (clear_issue || in_fire) begin
        pend_a   <= 1'b1;
        pend_d   <= 1'b1;
        wr_addr  <= ptr;
        accum_en <= in_fire;
      end else begin
        if (wr_ready) pend_a <= 1'b0;
        if (wready)   pend_d <= 1'b0;
      end
      case (state)
        CLEAR: begin
          if (clear_issue) begin
            ptr     <= ptr + 1'b1;
            row_cnt <= row_cnt + 1'b1;
          end else if (state_nxt != CLEAR) begin
            ptr     <= base_r;
            row_cnt <= '0;
          end
        end
        ACCUM: if (in_fire) begin
          if (row_cnt == rows_r - 1'b1) begin
            row_cnt  <= '0;
            ptr      <= base_r;
            pass_cnt <= pass_cnt + 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            ptr     <= ptr + 1'b1;
          end
        end
        DRAIN: begin
          if (rd_fire) begin
            ptr     <= ptr + 1'b1;
            row_cnt <= row_cnt + 1'b1;
          end
          if (pop) pop_cnt <= pop_cnt + 1'b1;
        end
        default: ;
      endcase
      case ({rd_fire, rvalid})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: ;
      endcase
      case ({rvalid, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: ;
      endcase
      if (rvalid) wp <= (wp == PW'(OUT_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop)    rp <= (rp == PW'(OUT_DEPTH - 1)) ? '0 : rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_issue)  wdata <= '0;
    else if (in_fire) wdata <= in_data;
    if (rvalid) mem[wp] <= rdata;
  end

`ifdef ACCUM_SEQ_PERF_EN
  logic stall;
  assign stall = (wr_valid && !wr_ready) || (wvalid && !wready) ||
                 (rd_valid && !rd_ready) || (out_valid && !out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (job_fire) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && !(&perf_cycles))  perf_cycles <= perf_cycles + 1'b1;
      if (stall && !(&perf_stalls)) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_accum_job_sequencer.sv
// Bench for accum_job_sequencer: a zone responder plus a reference model that predicts
// the write stream and drained rows of each job from the descriptor and input rows.
module tb_accum_job_sequencer;
  localparam int NB = 4, AW = 9, DW = 64, ZW = 2, OD = 4, W = NB * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, job_valid, job_ready, job_clear;
  logic [AW-1:0] job_base;
  logic [AW:0]   job_rows;
  logic [7:0]    job_passes;
  logic [NB-1:0] job_mask, wr_mask, rd_mask;
  logic [ZW-1:0] job_zone, wr_zone_id, rd_zone_id;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0]  in_data, out_data, wdata, rdata;
  logic          wr_valid, accum_en, wr_ready, wvalid, wready, rd_valid, rd_ready, rvalid, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;

  accum_job_sequencer #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZONE_WIDTH(ZW), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rstn(rstn), .job_valid(job_valid), .job_ready(job_ready), .job_base(job_base),
    .job_rows(job_rows), .job_passes(job_passes), .job_mask(job_mask), .job_zone(job_zone),
    .job_clear(job_clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .wr_valid(wr_valid), .accum_en(accum_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_zone_id(wr_zone_id), .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_mask(rd_mask),
    .rd_zone_id(rd_zone_id), .rvalid(rvalid), .rdata(rdata), .busy(busy), .done(done));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          acc;
    logic [NB-1:0] mask;
    logic [ZW-1:0] zone;
    logic [W-1:0]  data;
  } wr_t;

  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] zmem    [512][NB];
  logic [DW-1:0] ref_mem [512][NB];
  wr_t           exp_wr_q[$], wa_q[$];
  logic [W-1:0]  wd_q[$], in_q[$];
  logic [W:0]    exp_out_q[$];
  logic [AW-1:0] rsp_q[$];
  logic [AW-1:0] exp_rd_addr;
  logic [NB-1:0] cur_mask;
  logic [ZW-1:0] cur_zone;
  int rd_issued, rows_popped, done_cnt, wr_seen, n_exp_wr, nrows, wmode, out_block, vcyc;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] add16(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int l = 0; l < DW / 16; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
    return r;
  endfunction

  function automatic logic [W-1:0] zone_row(input logic [AW-1:0] a);
    logic [W-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = zmem[a][b];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_row(input logic [AW-1:0] a);
    logic [W-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = ref_mem[a][b];
    return r;
  endfunction

  // One clock of environment: drive responders at the falling edge, then record what the next rising edge takes.
  task automatic tick();
    wr_t a;
    @(negedge clk);
    if (wr_valid || wvalid) vcyc++;
    case (wmode)
      0: begin wr_ready = ($urandom % 3) != 0; wready = ($urandom % 3) != 0; end
      1: begin wready = 1'b1; wr_ready = (vcyc > 3); end
      default: begin wr_ready = 1'b1; wready = (vcyc > 3); end
    endcase
    rd_ready = ($urandom % 4) != 0;
    if (out_block > 0) begin out_ready = 1'b0; out_block--; end
    else out_ready = ($urandom % 4) != 0;
    if (in_q.size() > 0 && ($urandom % 4) != 0) begin in_valid = 1'b1; in_data = in_q[0]; end
    else in_valid = 1'b0;
    if (rsp_q.size() > 0 && ($urandom % 3) != 0) begin rvalid = 1'b1; rdata = zone_row(rsp_q[0]); end
    else rvalid = 1'b0;
    #1;
    if (wr_valid && wr_ready) begin
      a = '0; a.addr = wr_addr; a.acc = accum_en; a.mask = wr_mask; a.zone = wr_zone_id;
      wa_q.push_back(a);
    end
    if (wvalid && wready) wd_q.push_back(wdata);
    while (wa_q.size() > 0 && wd_q.size() > 0) begin
      a = wa_q.pop_front();
      a.data = wd_q.pop_front();
      for (int b = 0; b < NB; b++)
        if (a.mask[b]) zmem[a.addr][b] = a.acc ? add16(zmem[a.addr][b], a.data[b*DW +: DW]) : a.data[b*DW +: DW];
      vcyc = 0;
      wr_seen++;
      if (exp_wr_q.size() > 0) chk("wr_row", a, exp_wr_q.pop_front());
    end
    if (rd_valid && rd_ready) begin
      rsp_q.push_back(rd_addr);
      chk("rd_cmd", {rd_addr, rd_mask, rd_zone_id}, {exp_rd_addr, cur_mask, cur_zone});
      exp_rd_addr++;
      rd_issued++;
      chk("rd_credit", (rd_issued - rows_popped) <= OD, 1'b1);
    end
    if (rvalid) void'(rsp_q.pop_front());
    if (in_valid && in_ready) void'(in_q.pop_front());
    if (out_valid && out_ready) begin
      if (exp_out_q.size() > 0) chk("out_row", {out_last, out_data}, exp_out_q.pop_front());
      rows_popped++;
    end
    if (done) done_cnt++;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int rows, input int passes,
                           input logic [NB-1:0] mask, input logic [ZW-1:0] zone,
                           input logic clr, input int pat);
    logic [AW-1:0] ad;
    logic [W-1:0]  row;
    wr_t           e;
    nrows = (rows == 0) ? 1 : rows;
    cur_mask = mask; cur_zone = zone; exp_rd_addr = base;
    rd_issued = 0; rows_popped = 0; done_cnt = 0; wr_seen = 0;
    if (clr) for (int r = 0; r < nrows; r++) begin
      ad = base + AW'(r);
      e = '0; e.addr = ad; e.mask = mask; e.zone = zone;
      exp_wr_q.push_back(e);
      for (int b = 0; b < NB; b++) if (mask[b]) ref_mem[ad][b] = '0;
    end
    for (int p = 0; p < passes; p++) for (int r = 0; r < nrows; r++) begin
      ad = base + AW'(r);
      for (int b = 0; b < NB; b++)
        case (pat)
          1: row[b*DW +: DW] = DW'(r + b);
          2: row[b*DW +: DW] = 64'h0001_0001_0001_0001;
          default: row[b*DW +: DW] = {$urandom, $urandom};
        endcase
      in_q.push_back(row);
      e.addr = ad; e.acc = 1'b1; e.mask = mask; e.zone = zone; e.data = row;
      exp_wr_q.push_back(e);
      for (int b = 0; b < NB; b++) if (mask[b]) ref_mem[ad][b] = add16(ref_mem[ad][b], row[b*DW +: DW]);
    end
    n_exp_wr = exp_wr_q.size();
    for (int r = 0; r < nrows; r++) exp_out_q.push_back({r == nrows - 1, ref_row(base + AW'(r))});
    for (int t = 0; t < 50 && !job_ready; t++) tick();
    chk("job_ready", job_ready, 1'b1);
    job_valid = 1'b1; job_base = base; job_rows = (AW+1)'(rows); job_passes = 8'(passes);
    job_mask = mask; job_zone = zone; job_clear = clr;
    tick();
    job_valid = 1'b0;
    chk("busy_on_accept", {busy, job_ready}, 2'b10);
  endtask

  task automatic finish_job();
    for (int t = 0; t < 3000 && done_cnt == 0; t++) tick();
    tick();
    tick();
    chk("done_pulses", done_cnt, 1);
    chk("wr_count", wr_seen, n_exp_wr);
    chk("out_rows", rows_popped, nrows);
    chk("out_left", exp_out_q.size(), 0);
    chk("back_idle", {job_ready, busy, done}, 3'b100);
  endtask

  initial begin
    rstn = 1'b0; job_valid = 1'b0; job_base = '0; job_rows = '0; job_passes = '0;
    job_mask = '0; job_zone = '0; job_clear = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; wr_ready = 1'b0; wready = 1'b0; rd_ready = 1'b0; rvalid = 1'b0; rdata = '0;
    wmode = 0; out_block = 0; vcyc = 0;
    for (int i = 0; i < 512; i++) for (int b = 0; b < NB; b++) begin
      zmem[i][b] = {$urandom, $urandom};
      ref_mem[i][b] = zmem[i][b];
    end
    tick();
    tick();
    chk("reset_state", {job_ready, busy, done, wr_valid, wvalid, rd_valid, out_valid, out_last, in_ready}, 9'b1_0000_0000);
    rstn = 1'b1;
    tick();
    chk("post_reset", {job_ready, busy, wr_valid, wvalid, rd_valid, out_valid}, 6'b10_0000);

    start_job(9'h010, 4, 1, 4'hF, 2'd1, 1'b1, 1); finish_job();
    start_job(9'h040, 2, 3, 4'hF, 2'd2, 1'b1, 2); finish_job();
    start_job(9'h1FE, 4, 1, 4'hA, 2'd0, 1'b1, 0); finish_job();
    wmode = 1; start_job(9'h080, 3, 2, 4'hF, 2'd3, 1'b1, 0); finish_job();
    wmode = 2; start_job(9'h090, 3, 1, 4'h6, 2'd1, 1'b1, 0); finish_job();
    wmode = 0;
    start_job(9'h100, 8, 0, 4'hF, 2'd0, 1'b0, 0); out_block = 20; finish_job();
    start_job(9'h033, 1, 0, 4'hF, 2'd1, 1'b0, 0); finish_job();
    start_job(9'h034, 0, 1, 4'h3, 2'd2, 1'b0, 0); finish_job();
    for (int i = 0; i < 4; i++) begin
      start_job(AW'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                NB'($urandom), ZW'($urandom), 1'($urandom), 0);
      finish_job();
    end

    start_job(9'h150, 6, 2, 4'hF, 2'd0, 1'b1, 0);
    for (int t = 0; t < 300 && in_q.size() > 9; t++) tick();
    rstn = 1'b0;
    #1;
    chk("reset_mid_accum", {job_ready, busy, done, wr_valid, wvalid, rd_valid, out_valid, in_ready}, 8'b1000_0000);
    exp_wr_q.delete(); wa_q.delete(); wd_q.delete(); in_q.delete(); exp_out_q.delete(); rsp_q.delete();
    for (int i = 0; i < 512; i++) for (int b = 0; b < NB; b++) ref_mem[i][b] = zmem[i][b];
    tick();
    tick();
    rstn = 1'b1;
    tick();
    start_job(9'h150, 6, 2, 4'hF, 2'd0, 1'b1, 0); finish_job();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
